// File: rtl/multiplier_iter_reg.sv
// Iterative shift-add multiplier with valid/ready handshake, retiring STEP multiplier bits per cycle.
// Define MULT_ITER_SIGNED_EN for two's-complement operands (magnitudes multiplied, sign applied at the end).
module multiplier_iter_reg #(
  parameter int WIDTH = 64,
  parameter int STEP  = 1
) (
  input  logic                 iClk,
  input  logic                 iRstN,
  input  logic                 iClr,
  input  logic                 iEn,
  input  logic                 iValid,
  output logic                 oReady,
  input  logic [WIDTH-1:0]     iData0,
  input  logic [WIDTH-1:0]     iData1,
  output logic                 oValid,
  input  logic                 iReady,
  output logic [2*WIDTH-1:0]   oData,
  output logic                 oBusy
);

  localparam int NSTEPS = WIDTH / STEP;
  localparam int CNT_W  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSTEPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t               r_state;
  state_t               w_stateNext;
  logic                 w_accept;
  logic                 w_last;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_data;
  logic                 r_valid;
  logic [WIDTH-1:0]     w_magA;
  logic [WIDTH-1:0]     w_magB;
  logic [2*WIDTH-1:0]   w_partial;
  logic [2*WIDTH-1:0]   w_accNext;
  logic [2*WIDTH-1:0]   w_result;

`ifdef MULT_ITER_SIGNED_EN
  logic r_neg;
  // Magnitude of the most negative value still fits WIDTH bits when read as unsigned.
  assign w_magA   = iData0[WIDTH-1] ? (~iData0 + 1'b1) : iData0;
  assign w_magB   = iData1[WIDTH-1] ? (~iData1 + 1'b1) : iData1;
  assign w_result = r_neg ? (~w_accNext + 1'b1) : w_accNext;

  always_ff @(posedge iClk) begin
    if (!iRstN || iClr) begin
      r_neg <= 1'b0;
    end else if (iEn && w_accept) begin
      r_neg <= iData0[WIDTH-1] ^ iData1[WIDTH-1];
    end
  end
`else
  assign w_magA   = iData0;
  assign w_magB   = iData1;
  assign w_result = w_accNext;
`endif

  // The multiplicand is pre-shifted each cycle, so each slice bit just adds a fixed shift of it.
  always_comb begin
    w_partial = '0;
    for (int j = 0; j < STEP; j++) begin
      if (r_mplier[j]) begin
        w_partial = w_partial + (r_mcand << j);
      end
    end
    w_accNext = r_acc + w_partial;
  end

  always_ff @(posedge iClk) begin
    if (!iRstN || iClr) begin
      r_state <= S_IDLE;
    end else if (iEn) begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    oReady      = 1'b0;
    oBusy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        oReady = 1'b1;
        if (iValid) begin
          w_accept    = 1'b1;
          w_stateNext = S_CALC;
        end
      end
      S_CALC: begin
        oBusy = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_last      = 1'b1;
          w_stateNext = S_DONE;
        end
      end
      S_DONE: begin
        if (iReady) begin
          w_stateNext = S_IDLE;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRstN || iClr) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
    end else if (iEn) begin
      if (w_accept) begin
        r_mcand  <= {{WIDTH{1'b0}}, w_magA};
        r_mplier <= w_magB;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (r_state == S_CALC) begin
        r_acc    <= w_accNext;
        r_mcand  <= r_mcand << STEP;
        r_mplier <= r_mplier >> STEP;
        r_cnt    <= r_cnt + 1'b1;
        if (w_last) begin
          r_data  <= w_result;
          r_valid <= 1'b1;
        end
      end else if (r_state == S_DONE && iReady) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign oData  = r_data;
  assign oValid = r_valid;

endmodule
